// File: rtl/evm_arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic units (multiplier, divider).
package evm_arith_pkg;

    // Native word width of the arithmetic units; narrower instances cast these down.
    localparam int unsigned ARITH_WIDTH = 256;

    localparam logic [ARITH_WIDTH-1:0] ZEROS = '0;
    localparam logic [ARITH_WIDTH-1:0] ONE   = ARITH_WIDTH'(1);

    // Sequencing states shared by the iterative arithmetic units.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StCalc = 2'd2,
        StDone = 2'd3
    } arith_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// with short-cut results for zero and unit operands.
module shift_add_mul
    import evm_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             start,
    output logic             ready,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    localparam int unsigned        CNT_W    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   W_ZERO   = WIDTH'(ZEROS);
    localparam logic [WIDTH-1:0]   W_ONE    = WIDTH'(ONE);
    // Counter value seen during the final CALC cycle (before its increment).
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    arith_state_t     state_q, state_d;
    logic [WIDTH-1:0] m_q, a_q, q_q;
    logic [WIDTH-1:0] res_hi_q, res_lo_q;
    logic [CNT_W-1:0] cnt_q;

    logic             op_zero, m_one, q_one, trivial;
    logic [WIDTH-1:0] triv_lo;
    logic [WIDTH:0]   sum;

    // Operand short-cut detection and the inline WIDTH+1-bit adder.
    always_comb begin
        op_zero = (multiplicand == W_ZERO) || (multiplier == W_ZERO);
        m_one   = (multiplicand == W_ONE);
        q_one   = (multiplier == W_ONE);
        trivial = op_zero || m_one || q_one;
        if (op_zero) begin
            triv_lo = W_ZERO;
        end else if (m_one) begin
            triv_lo = multiplier;
        end else begin
            triv_lo = multiplicand;
        end
        // Carry out lands in sum[WIDTH] and is folded into A by the shift.
        sum = {1'b0, a_q} + {1'b0, (q_q[0] ? m_q : W_ZERO)};
    end

    // Next-state and output decode; reset forces quiet outputs immediately.
    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        product_hi = res_hi_q;
        product_lo = res_lo_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                if (trivial) begin
                    ready      = 1'b1;
                    product_hi = W_ZERO;
                    product_lo = triv_lo;
                    state_d    = StIdle;
                end else begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == LAST_CNT) state_d = StDone;
            end
            StDone: begin
                ready      = 1'b1;
                product_hi = a_q;
                product_lo = q_q;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (!rst) begin
            state_d    = StIdle;
            ready      = 1'b0;
            product_hi = W_ZERO;
            product_lo = W_ZERO;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: operand load, shift-add iteration and result capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_q      <= W_ZERO;
            a_q      <= W_ZERO;
            q_q      <= W_ZERO;
            cnt_q    <= '0;
            res_hi_q <= W_ZERO;
            res_lo_q <= W_ZERO;
        end else begin
            case (state_q)
                StLoad: begin
                    if (trivial) begin
                        res_hi_q <= W_ZERO;
                        res_lo_q <= triv_lo;
                    end else begin
                        m_q   <= multiplicand;
                        a_q   <= W_ZERO;
                        q_q   <= multiplier;
                        cnt_q <= '0;
                    end
                end
                StCalc: begin
                    // {C,A,Q} >> 1 with {C,A} = sum.
                    a_q   <= sum[WIDTH:1];
                    q_q   <= {sum[0], q_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                end
                StDone: begin
                    res_hi_q <= a_q;
                    res_lo_q <= q_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mul.sv
// Randomised self-checking bench for shift_add_mul (8-bit and 256-bit instances).
module tb_shift_add_mul;

    localparam int unsigned W  = 8;
    localparam int unsigned WB = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [W-1:0]   mc, mp, plo, phi;
    logic           start, ready;
    logic [WB-1:0]  mc_b, mp_b, plo_b, phi_b;
    logic           start_b, ready_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    shift_add_mul #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .multiplicand(mc), .multiplier(mp), .start(start),
        .ready(ready), .product_lo(plo), .product_hi(phi)
    );

    shift_add_mul #(.WIDTH(WB)) u_dut_wide (
        .clk(clk), .rst(rst), .multiplicand(mc_b), .multiplier(mp_b), .start(start_b),
        .ready(ready_b), .product_lo(plo_b), .product_hi(phi_b)
    );

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit multiplication; expectations come from plain arithmetic and the
    // latency rule (trivial operands answer in LOAD, others WIDTH+1 edges later).
    task automatic run8(input logic [W-1:0] m, input logic [W-1:0] q, input bit repulse,
                        input string tag);
        logic [2*W-1:0] prod;
        int             exp_lat, lat, pulses;
        logic [W-1:0]   got_hi, got_lo;
        prod    = {{W{1'b0}}, m} * {{W{1'b0}}, q};
        exp_lat = (m == 0 || q == 0 || m == 1 || q == 1) ? 0 : W + 1;
        @(negedge clk);
        mc = m; mp = q; start = 1'b1;
        @(posedge clk);
        lat = -1; pulses = 0; got_hi = '0; got_lo = '0;
        for (int k = 0; k < 2 * W + 8; k++) begin
            @(negedge clk);
            if (ready) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; got_hi = phi; got_lo = plo;
                end
            end
            start = (repulse && k == 3) ? 1'b1 : 1'b0;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_pulses"}, pulses, 1);
        check_eq({tag, "_hi"}, got_hi, prod[2*W-1:W]);
        check_eq({tag, "_lo"}, got_lo, prod[W-1:0]);
        check_eq({tag, "_hold"}, {phi, plo}, prod);
    endtask

    initial begin
        int pulses, lat;
        logic [W-1:0]   rm, rq;
        logic [511:0]   prod_b;

        rst = 1'b0; start = 1'b0; mc = '0; mp = '0;
        start_b = 1'b0; mc_b = '0; mp_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", ready, 1'b0);
        check_eq("rst_prod", {phi, plo}, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", ready, 1'b0);
        check_eq("post_rst_prod", {phi, plo}, 0);
        check_eq("post_rst_wide", {ready_b, phi_b, plo_b}, 0);

        run8(8'd13, 8'd11, 1'b0, "m13_q11");
        run8(8'd255, 8'd255, 1'b0, "m255_q255");
        run8(8'd0, 8'd77, 1'b0, "m0_q77");
        run8(8'd1, 8'd200, 1'b0, "m1_q200");
        run8(8'd9, 8'd1, 1'b0, "m9_q1");
        run8(8'd100, 8'd3, 1'b1, "repulse");

        // Reset asserted for one cycle in the middle of CALC.
        @(negedge clk);
        mc = 8'd200; mp = 8'd150; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_during", {ready, phi, plo}, 0);
        @(negedge clk);
        rst = 1'b1;
        check_eq("midrst_after", {ready, phi, plo}, 0);
        pulses = 0;
        repeat (W + 6) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check_eq("midrst_no_ready", pulses, 0);
        check_eq("midrst_quiet", {phi, plo}, 0);
        run8(8'd6, 8'd7, 1'b0, "m6_q7");

        // Random operands, biased toward the short-cut values now and then.
        for (int i = 0; i < 24; i++) begin
            rm = W'($urandom);
            rq = W'($urandom);
            if ($urandom_range(0, 5) == 0) rm = W'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) rq = W'($urandom_range(0, 1));
            run8(rm, rq, 1'b0, $sformatf("rand%0d", i));
        end

        // Full-width all-ones operands on the 256-bit instance.
        @(negedge clk);
        mc_b = '1; mp_b = '1; start_b = 1'b1;
        prod_b = {{WB{1'b0}}, mc_b} * {{WB{1'b0}}, mp_b};
        @(posedge clk);
        lat = -1; pulses = 0;
        for (int k = 0; k < WB + 8; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (ready_b) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    check_eq("wide_hi", phi_b, prod_b[2*WB-1:WB]);
                    check_eq("wide_lo", plo_b, prod_b[WB-1:0]);
                end
            end
        end
        check_eq("wide_lat", lat, WB + 1);
        check_eq("wide_pulses", pulses, 1);
        check_eq("wide_hold", {phi_b, plo_b}, prod_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 SHALL have parameter: WIDTH, default 256, operand width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all registers update on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: multiplicand  input  WIDTH  unsigned operand M.
REQ-005 SHALL have port: multiplier  input  WIDTH  unsigned operand Q.
REQ-006 SHALL have port: start  input  1  request a new multiplication.
REQ-007 SHALL have port: ready  output  1  one-cycle pulse; product valid.
REQ-008 SHALL have port: product_lo  output  WIDTH  low WIDTH bits of M*Q.
REQ-009 SHALL have port: product_hi  output  WIDTH  high WIDTH bits of M*Q.

Function
REQ-010 SHALL implement an FSM with states IDLE, LOAD, CALC, DONE.
REQ-011 SHALL go IDLE -> LOAD on the first clk edge where start=1; in IDLE, start=0 stays in IDLE.
REQ-012 SHALL sample multiplicand and multiplier in the LOAD cycle; the caller holds both stable from start through LOAD.
REQ-013 SHALL, in LOAD with either operand 0: drive ready=1 combinationally, product_hi=product_lo=0, register that result, and return to IDLE.
REQ-014 SHALL, in LOAD with multiplicand==1 (other operand nonzero): ready=1, product_lo=multiplier, product_hi=0, register it, return to IDLE.
REQ-015 SHALL, in LOAD with multiplier==1 (other operand nonzero and not 1): ready=1, product_lo=multiplicand, product_hi=0, register it, return to IDLE.
REQ-016 SHALL otherwise load M, load accumulator A=0, carry C=0, Q=multiplier, counter=0, then enter CALC.
REQ-017 SHALL, in each CALC cycle: compute {C,A} = A + (Q[0] ? M : 0) as a WIDTH+1-bit sum, shift {C,A,Q} right by one, and increment counter.
REQ-018 SHALL leave CALC for DONE after exactly WIDTH CALC cycles (counter reaches WIDTH).
REQ-019 SHALL, in DONE: assert ready=1 for exactly one cycle, drive product_hi=A and product_lo=Q, then return to IDLE.
REQ-020 SHALL have a normal-path latency of 1+WIDTH+1 cycles: start sampled at edge n gives ready high during cycle n+WIDTH+2.
REQ-021 SHALL hold product_hi/product_lo at the last result after ready, until the next LOAD.
REQ-022 SHALL ignore start in LOAD, CALC and DONE; there is no abort or queuing.
REQ-023 SHALL keep ready=0 in every state and cycle not named in REQ-013..REQ-015 and REQ-019.
REQ-024 SHALL produce the exact 2*WIDTH-bit unsigned product with no overflow; the MSB carry is folded into A by the shift.
REQ-025 SHALL, on an illegal state encoding, go to IDLE with ready=0.

Reset
REQ-026 SHALL, when rst=0 at a clk edge: state=IDLE; A, Q, M, C, counter and result registers = 0.
REQ-027 SHALL, during and after reset, drive ready=0 and product_hi=product_lo=0 until the next result.
REQ-028 SHALL abandon an operation if reset is asserted mid-operation (any state); no ready pulse follows for it.

Structure
REQ-029 SHALL declare the FSM state typedef and WIDTH-sized ZEROS/ONE constants in a shared package evm_arith_pkg, also usable by the divider.
REQ-030 SHALL be a single module with no sub-modules; the adder is inline, and the register update and FSM are separate sequential/combinational processes.

Verification (bench WIDTH=8 unless noted)
REQ-031 SHALL cover: M=13, Q=11, start at edge n -> ready during cycle n+10, hi=0x00, lo=0x8F.
REQ-032 SHALL cover: M=255, Q=255 -> hi=0xFE, lo=0x01 (carry path exercised).
REQ-033 SHALL cover: M=0, Q=77 -> ready in the LOAD cycle, hi=lo=0; then M=1, Q=200 -> ready in LOAD, lo=200, hi=0; then M=9, Q=1 -> lo=9, hi=0.
REQ-034 SHALL cover: M=100, Q=3 with start re-pulsed during CALC -> single ready, lo=0x2C, hi=0x01; no second operation started.
REQ-035 SHALL cover: rst=0 for one cycle mid-CALC -> no ready, outputs 0, state IDLE; a following 6*7 gives lo=42.
REQ-036 SHALL cover: WIDTH=256, M=Q=2^256-1 -> hi=2^256-2, lo=1, ready at start+258 cycles.
